sr_flipflop_bank: RTL and testbench
===================================

Name: sr_flipflop_bank

Overview:
- Parametrised multi-channel successor to the single SR flip-flop: WIDTH independent storage bits sharing one clock and a runtime-selectable mode (SR, JK, D, T).
- The SR "11" input is a deterministic, detected condition: the bit holds and a sticky per-channel violation flag sets, instead of leaving the output undefined.
- Used as the generic control/status bit bank in sequential-circuit designs and benches.

Parameters:
- WIDTH, 4, number of independent flip-flop channels (≥1).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- CNT_W, 8, width of the optional violation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  WIDTH  per-channel clock enable; 0 holds that channel.
- mode  input  2  global mode: 00 SR, 01 JK, 10 D, 11 T.
- s  input  WIDTH  S / J / D / T input, depending on mode.
- r  input  WIDTH  R / K input; ignored in D and T modes.
- clr_invalid  input  1  synchronous clear of invalid flags (and of err_count when present).
- q  output  WIDTH  stored state.
- qbar  output  WIDTH  always ~q, combinationally; never equal to q.
- invalid  output  WIDTH  sticky per-channel flag; set on SR-mode s=r=1 with en=1.
- err_count  output  CNT_W  present only with SRFF_ERRCNT_EN.

Behaviour:
- Reset, asynchronous on the falling edge of rst_n, held while low:
  - q = RESET_VAL; qbar = ~RESET_VAL.
  - invalid = 0; err_count = 0.
- Reset asserted mid-operation overrides everything immediately.
- First update after release: first rising clk with rst_n=1.
- Latency: q updates on the rising clk edge where inputs are sampled. 1 cycle; no combinational path from s/r to q.
- Per channel i, with en[i]=1 at the edge:
  - SR mode:
    - 00 → hold.
    - 10 → q=1.
    - 01 → q=0.
    - 11 → hold, and invalid[i] sets.
  - JK mode: 00 hold, 10 set, 01 reset, 11 toggle. No flag.
  - D mode: q=s[i].
  - T mode: s[i]=1 toggles, s[i]=0 holds.
- en[i]=0: q[i] holds and invalid[i] is not set, whatever the mode or inputs.
- A mode change takes effect at the next edge. No state is reset on a mode change.
- clr_invalid=1 clears all invalid bits at the edge. If a channel violates in the same cycle, set wins: that bit ends at 1.
- The invalid flags are independent of q. No other state machine exists; each channel is a 1-bit state with 4 transition rules.

Optional Feature:
- Macro: SRFF_ERRCNT_EN.
- With the macro: err_count increments by 1 on each edge where at least one channel registers an SR violation, regardless of how many channels violate.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_invalid clears it. If clr_invalid and a violation occur in the same cycle, the result is 1.
- Without the macro: no err_count port, no counter logic. All other behaviour is identical.

Decomposition:
- Package sr_flipflop_pkg:
  - mode typedef/localparams: MODE_SR=2'b00, MODE_JK=2'b01, MODE_D=2'b10, MODE_T=2'b11.
  - Helper function returning the next state for (mode, s, r, q).
- Sub-module ff_cell:
  - One channel: next-state logic plus its q register and violation detect.
  - Instantiated WIDTH times via generate.
- The top level holds the invalid register, the optional counter, and the qbar assignment.

Test Plan (WIDTH=4, RESET_VAL=4'b0101):
- Hold rst_n=0 for 2 edges, then release → q=0101, qbar=1010, invalid=0000. Pull rst_n low between edges → q snaps to 0101 before the next edge.
- SR mode, en=1111, s=0011, r=1100 → q=0011 after one edge. Then s=0000, r=0000 → q holds 0011.
- SR mode, s=r=1001, en=1111 → q unchanged, invalid=1001. Then clr_invalid=1 with s=r=0000 → invalid=0000. Then clr_invalid=1 with s=r=0001 → invalid=0001.
- JK mode from q=0000, s=r=1111 → q toggles 1111, 0000, 1111 on successive edges; invalid stays 0000. T mode with s=0101 → q alternates bits 0 and 2 only.
- D mode, s=1010, r=1111, en=0011 → q[1:0]=10, q[3:2] hold. SR mode s=r=1111 with en=0000 → no invalid set.
- SRFF_ERRCNT_EN, CNT_W=2:
  - 5 violating edges → err_count=3 (saturated).
  - Violation on 2 channels in one edge → +1 only.
  - clr_invalid together with a violation → err_count=1.

Source files
------------

// File: rtl/sr_flipflop_pkg.sv
// rtl/sr_flipflop_pkg.sv - mode encodings and next-state rule for the flip-flop bank
package sr_flipflop_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  // SR "11" holds here; flagging the violation is the caller's job.
  function automatic logic ff_next(input mode_e mode, input logic s, input logic r,
                                   input logic q);
    logic nxt;
    nxt = q;
    unique case (mode)
      MODE_SR: begin
        if (s && !r)      nxt = 1'b1;
        else if (!s && r) nxt = 1'b0;
        else              nxt = q;
      end
      MODE_JK: begin
        unique case ({s, r})
          2'b10:   nxt = 1'b1;
          2'b01:   nxt = 1'b0;
          2'b11:   nxt = ~q;
          default: nxt = q;
        endcase
      end
      MODE_D:  nxt = s;
      MODE_T:  nxt = s ? ~q : q;
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// rtl/ff_cell.sv - one flip-flop channel: next-state logic, q register, SR violation detect
module ff_cell
  import sr_flipflop_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       s,
  input  logic       r,
  output logic       q,
  output logic       viol
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = ff_next(mode_e'(mode), s, r, q_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RESET_BIT;
    else        q_q <= q_d;
  end

  assign viol = en && (mode == MODE_SR) && s && r;
  assign q    = q_q;

endmodule

// File: rtl/sr_flipflop_bank.sv
// rtl/sr_flipflop_bank.sv - WIDTH-channel SR/JK/D/T bit bank with sticky violation flags
// Optional saturating violation counter enabled by SRFF_ERRCNT_EN.
module sr_flipflop_bank
  import sr_flipflop_pkg::*;
#(
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter int unsigned          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_invalid,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
`ifdef SRFF_ERRCNT_EN
  output logic [CNT_W-1:0] err_count,
`endif
  output logic [WIDTH-1:0] invalid
);

  logic [WIDTH-1:0] viol;
  logic [WIDTH-1:0] invalid_q;
  logic [WIDTH-1:0] invalid_d;
  logic             any_viol;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RESET_BIT(RESET_VAL[i])
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en[i]),
      .mode (mode),
      .s    (s[i]),
      .r    (r[i]),
      .q    (q[i]),
      .viol (viol[i])
    );
  end

  assign any_viol = |viol;

  // A violation in the clearing cycle survives the clear.
  always_comb begin
    invalid_d = invalid_q | viol;
    if (clr_invalid) invalid_d = viol;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) invalid_q <= '0;
    else        invalid_q <= invalid_d;
  end

`ifdef SRFF_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_invalid)                       cnt_d = any_viol ? CNT_W'(1) : '0;
    else if (any_viol && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;
`else
  logic unused_any_viol;
  assign unused_any_viol = any_viol;
`endif

  assign invalid = invalid_q;
  assign qbar    = ~q;

endmodule

// File: tb/tb_sr_flipflop_bank.sv
// tb/tb_sr_flipflop_bank.sv - directed self-checking bench for sr_flipflop_bank
module tb_sr_flipflop_bank;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             clr_invalid;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] invalid;
`ifdef SRFF_ERRCNT_EN
  logic [CNT_W-1:0] err_count;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sr_flipflop_bank #(
    .WIDTH    (WIDTH),
    .RESET_VAL(4'b0101),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .s          (s),
    .r          (r),
    .clr_invalid(clr_invalid),
    .q          (q),
    .qbar       (qbar),
`ifdef SRFF_ERRCNT_EN
    .err_count  (err_count),
`endif
    .invalid    (invalid)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] m, input logic [3:0] e, input logic [3:0] sv,
                       input logic [3:0] rv, input logic c);
    mode = m; en = e; s = sv; r = rv; clr_invalid = c;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    tick();
    check("reset_q", {4'b0, q}, 8'b0101);
    check("reset_qbar", {4'b0, qbar}, 8'b1010);
    check("reset_invalid", {4'b0, invalid}, 8'b0000);
    rst_n = 1'b1;

    drive(2'b10, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    tick();
    check("d_clear_before_async", {4'b0, q}, 8'b0000);
    rst_n = 1'b0;
    #2;
    check("async_reset_q", {4'b0, q}, 8'b0101);
    rst_n = 1'b1;
    @(negedge clk);

    drive(2'b00, 4'b1111, 4'b0011, 4'b1100, 1'b0);
    tick();
    check("sr_set_reset", {4'b0, q}, 8'b0011);
    drive(2'b00, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    tick();
    check("sr_hold", {4'b0, q}, 8'b0011);
    check("sr_hold_qbar", {4'b0, qbar}, 8'b1100);

    drive(2'b00, 4'b1111, 4'b1001, 4'b1001, 1'b0);
    tick();
    check("sr_viol_q", {4'b0, q}, 8'b0011);
    check("sr_viol_flag", {4'b0, invalid}, 8'b1001);
    drive(2'b00, 4'b1111, 4'b0000, 4'b0000, 1'b1);
    tick();
    check("clr_invalid", {4'b0, invalid}, 8'b0000);
    drive(2'b00, 4'b1111, 4'b0001, 4'b0001, 1'b1);
    tick();
    check("clr_vs_viol", {4'b0, invalid}, 8'b0001);
    drive(2'b00, 4'b1111, 4'b0000, 4'b0000, 1'b1);
    tick();
    check("clr_again", {4'b0, invalid}, 8'b0000);

    drive(2'b10, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    tick();
    check("d_zero", {4'b0, q}, 8'b0000);
    drive(2'b01, 4'b1111, 4'b1111, 4'b1111, 1'b0);
    tick();
    check("jk_toggle1", {4'b0, q}, 8'b1111);
    tick();
    check("jk_toggle2", {4'b0, q}, 8'b0000);
    tick();
    check("jk_toggle3", {4'b0, q}, 8'b1111);
    check("jk_no_flag", {4'b0, invalid}, 8'b0000);

    drive(2'b11, 4'b1111, 4'b0101, 4'b0000, 1'b0);
    tick();
    check("t_toggle1", {4'b0, q}, 8'b1010);
    tick();
    check("t_toggle2", {4'b0, q}, 8'b1111);

    drive(2'b10, 4'b0011, 4'b1010, 4'b1111, 1'b0);
    tick();
    check("d_partial_en", {4'b0, q}, 8'b1110);
    drive(2'b00, 4'b0000, 4'b1111, 4'b1111, 1'b0);
    tick();
    check("sr_viol_en0_flag", {4'b0, invalid}, 8'b0000);
    check("sr_viol_en0_q", {4'b0, q}, 8'b1110);

`ifdef SRFF_ERRCNT_EN
    check("cnt_start", {6'b0, err_count}, 8'd0);
    drive(2'b00, 4'b1111, 4'b0011, 4'b0011, 1'b0);
    tick();
    check("cnt_two_channels", {6'b0, err_count}, 8'd1);
    for (int i = 0; i < 4; i++) tick();
    check("cnt_saturate", {6'b0, err_count}, 8'd3);
    check("cnt_flags", {4'b0, invalid}, 8'b0011);
    drive(2'b00, 4'b1111, 4'b1000, 4'b1000, 1'b1);
    tick();
    check("cnt_clr_vs_viol", {6'b0, err_count}, 8'd1);
    check("cnt_clr_flags", {4'b0, invalid}, 8'b1000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
